// File: rtl/hdmi_pkg.sv
// Shared TMDS definitions: control tokens, word/disparity widths and a ones counter
// used by every channel encoder of the HDMI/DVI transmitter.
package hdmi_pkg;

  localparam int TMDS_W = 10;
  localparam int DISP_W = 5;

  localparam logic [TMDS_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// Three-stage pipelined TMDS 8b/10b encoder for one colour channel: transition
// minimisation, then DC balancing against a running disparity, or control tokens in blanking.
module tmds_encoder
  import hdmi_pkg::*;
(
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        data_in,
  input  logic              c0,
  input  logic              c1,
  input  logic              de,
  output logic [TMDS_W-1:0] data_out
);

  logic       vld_1, vld_2;
  logic       de_1, c0_1, c1_1;
  logic [7:0] data_1;
  logic [3:0] n1_d;

  logic       de_2, c0_2, c1_2;
  logic [8:0] q_m;
  logic [3:0] n1_qm, n0_qm;

  logic signed [DISP_W-1:0] cnt;
  logic signed [DISP_W-1:0] cnt_next;
  logic [TMDS_W-1:0]        out_next;

  logic       use_xnor;
  logic [8:0] q_m_comb;
  logic [3:0] n1_comb;

  function automatic logic [8:0] build_qm(input logic [7:0] d, input logic xnor_sel);
    logic [8:0] q;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = xnor_sel ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~xnor_sel;
    return q;
  endfunction

  // The valid bits keep data_out at 0 until real samples have filled the pipe.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_1  <= 1'b0;
      de_1   <= 1'b0;
      c0_1   <= 1'b0;
      c1_1   <= 1'b0;
      data_1 <= 8'd0;
      n1_d   <= 4'd0;
    end else begin
      vld_1  <= 1'b1;
      de_1   <= de;
      c0_1   <= c0;
      c1_1   <= c1;
      data_1 <= data_in;
      n1_d   <= popcount8(data_in);
    end
  end

  always_comb begin
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data_1[0]);
    q_m_comb = build_qm(data_1, use_xnor);
    n1_comb  = popcount8(q_m_comb[7:0]);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_2 <= 1'b0;
      de_2  <= 1'b0;
      c0_2  <= 1'b0;
      c1_2  <= 1'b0;
      q_m   <= 9'd0;
      n1_qm <= 4'd0;
      n0_qm <= 4'd0;
    end else begin
      vld_2 <= vld_1;
      de_2  <= de_1;
      c0_2  <= c0_1;
      c1_2  <= c1_1;
      q_m   <= q_m_comb;
      n1_qm <= n1_comb;
      n0_qm <= 4'd8 - n1_comb;
    end
  end

  // DC balancing: choose whether to invert q_m[7:0] so the running disparity heads to 0.
  always_comb begin
    logic signed [DISP_W-1:0] n1_s, n0_s, diff;
    logic                     cnt_pos, cnt_neg;
    out_next = '0;
    cnt_next = cnt;
    n1_s     = signed'({1'b0, n1_qm});
    n0_s     = signed'({1'b0, n0_qm});
    diff     = n1_s - n0_s;
    cnt_pos  = !cnt[DISP_W-1] && (cnt != '0);
    cnt_neg  = cnt[DISP_W-1];
    if (!vld_2) begin
      out_next = '0;
      cnt_next = '0;
    end else if (!de_2) begin
      cnt_next = '0;
      unique case ({c1_2, c0_2})
        2'b00:   out_next = CTRL_00;
        2'b01:   out_next = CTRL_01;
        2'b10:   out_next = CTRL_10;
        default: out_next = CTRL_11;
      endcase
    end else if ((cnt == '0) || (n1_qm == n0_qm)) begin
      out_next = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_next = q_m[8] ? (cnt + diff) : (cnt - diff);
    end else if ((cnt_pos && (n1_qm > n0_qm)) || (cnt_neg && (n0_qm > n1_qm))) begin
      out_next = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_next = cnt + (q_m[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      out_next = {1'b0, q_m[8], q_m[7:0]};
      cnt_next = cnt - (q_m[8] ? 5'sd0 : 5'sd2) + diff;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_out <= '0;
      cnt      <= '0;
    end else begin
      data_out <= out_next;
      cnt      <= cnt_next;
    end
  end

endmodule
